uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_rx_fifo.sv | 111 +++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART types for the receive path.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the CPU bus: circular buffer, first-word fall-through.
// Optional overflow drop counter enabled by defining UART_RX_FIFO_DROP_CNT_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned Depth           = 16,
  parameter int unsigned AlmostFullLevel = 12
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  uart_byte_t                 i_in_bits,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output uart_byte_t                 o_out_bits,
  input  logic                       i_flush,
  output logic [$clog2(Depth+1)-1:0] o_level,
`ifdef UART_RX_FIFO_DROP_CNT_EN
  output logic [15:0]                o_drop_count,
`endif
  output logic                       o_almost_full
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned LevelW = $clog2(Depth + 1);

  uart_byte_t        mem [Depth];
  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW-1:0]   rd_ptr;
  logic [LevelW-1:0] count;
  logic [LevelW-1:0] count_next;
  logic              out_valid_q;
  logic              not_full_q;
  logic              af_q;
  logic              push_c;
  logic              pop_c;

  assign pop_c = out_valid_q && i_out_ready;

`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  logic        drop_c;

  // Always ready; a full FIFO only takes the byte if a pop frees a slot this cycle.
  assign o_in_ready   = 1'b1;
  assign push_c       = i_in_valid && (not_full_q || pop_c);
  assign drop_c       = i_in_valid && !not_full_q && !pop_c;
  assign o_drop_count = drop_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      drop_cnt_q <= '0;
    end else if (drop_c && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end
`else
  assign o_in_ready = not_full_q;
  assign push_c     = i_in_valid && not_full_q;
`endif

  assign o_out_valid   = out_valid_q;
  assign o_out_bits    = mem[rd_ptr];
  assign o_level       = count;
  assign o_almost_full = af_q;

  // Next occupancy; flush wins over any concurrent push or pop.
  always_comb begin
    count_next = count;
    if (i_flush) begin
      count_next = '0;
    end else if (push_c && !pop_c) begin
      count_next = count + LevelW'(1);
    end else if (pop_c && !push_c) begin
      count_next = count - LevelW'(1);
    end
  end

  // Status flags are registered from the next occupancy so they track count exactly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
      not_full_q  <= 1'b1;
      af_q        <= (AlmostFullLevel == 0);
    end else begin
      count       <= count_next;
      out_valid_q <= (count_next != '0);
      not_full_q  <= (count_next != LevelW'(Depth));
      af_q        <= (count_next >= LevelW'(AlmostFullLevel));
      if (i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_c) wr_ptr <= wr_ptr + PtrW'(1);
        if (pop_c)  rd_ptr <= rd_ptr + PtrW'(1);
      end
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (push_c && !i_flush && !i_rst) begin
      mem[wr_ptr] <= i_in_bits;
    end
  end

endmodule
